// File: rtl/alut_apb_seq28.sv
// alut_apb_seq28: command FIFO feeding a zero-wait APB master for the
// ALUT veneer, with a single-entry valid/ready read-response slot.
module alut_apb_seq28 #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32
) (
    input  logic              pclk28,
    input  logic              p_reset28,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [EW-1:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW-1:0]     w_hidx;
    logic [CW-1:0]     r_count;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_in_access;
    logic              w_cur_wr;
    logic [EW-1:0]     w_head;
    logic              w_head_wr;
    logic              w_head_vld;
    logic              w_elig;

    assign cmd_ready   = (r_count != CW'(FIFO_DEPTH));
    assign w_push      = cmd_valid & cmd_ready;
    assign w_in_access = (r_state == S_ACCESS);
    assign w_pop       = w_in_access;
    assign w_cur_wr    = r_mem[r_rptr][EW-1];

    // In ACCESS the current head pops on this edge, so look one entry ahead.
    assign w_hidx     = r_rptr + PW'(w_in_access);
    assign w_head     = r_mem[w_hidx];
    assign w_head_wr  = w_head[EW-1];
    assign w_head_vld = w_in_access ? (r_count > CW'(1)) : (r_count != '0);
    assign w_elig     = w_head_vld &
                        (w_head_wr | (~r_rsp_valid & ~(w_in_access & ~w_cur_wr)));

    always_ff @(posedge pclk28) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge pclk28 or posedge p_reset28) begin
        if (p_reset28) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge pclk28 or posedge p_reset28) begin
        if (p_reset28) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_elig) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: w_next = w_elig ? S_SETUP : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk28 or posedge p_reset28) begin
        if (p_reset28) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_psel    <= (w_next != S_IDLE);
            r_penable <= (w_next == S_ACCESS);
            if (w_next == S_SETUP) begin
                r_pwrite <= w_head_wr;
                r_paddr  <= w_head[DATA_W +: ADDR_W];
                r_pwdata <= w_head_wr ? w_head[DATA_W-1:0] : '0;
            end
        end
    end

    always_ff @(posedge pclk28 or posedge p_reset28) begin
        if (p_reset28) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_pop && !w_cur_wr) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= prdata;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (r_count != '0) || (r_state != S_IDLE) || r_rsp_valid;

endmodule

// File: tb/tb_alut_apb_seq28.sv
// Bench for alut_apb_seq28: a register-file veneer plus an in-order
// command/response reference model.
module tb_alut_apb_seq28;
    localparam int AW = 7;
    localparam int DW = 32;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] vmem [128];
    logic [DW-1:0] mreg [128];
    xfer_t         apb_log [$];
    xfer_t         exp_apb [$];
    logic [DW-1:0] rsp_log [$];
    logic [DW-1:0] exp_rsp [$];

    alut_apb_seq28 dut (
        .pclk28   (clk),
        .p_reset28(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign prdata = vmem[paddr];

    always @(posedge clk) begin
        if (psel && penable) begin
            apb_log.push_back({pwrite, paddr, pwdata});
            if (pwrite) vmem[paddr] <= pwdata;
        end
        if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_rdata);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        apb_log.delete();
        exp_apb.delete();
        rsp_log.delete();
        exp_rsp.delete();
    endtask

    // Reference: transfers complete in command order; reads return the
    // latest value written to that address.
    task automatic model_cmd(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        exp_apb.push_back({w, a, (w ? d : 32'h0)});
        if (w) mreg[a] = d;
        else   exp_rsp.push_back(mreg[a]);
    endtask

    task automatic drain(input string tag);
        int t;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        t = 0;
        while (busy !== 1'b0 && t < 300) begin
            tick;
            t++;
        end
        n_vec++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s drain: busy=%b after %0d cycles, want 0", tag, busy, t);
        end
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({psel, penable, pwrite, rsp_valid, busy, paddr, pwdata, rsp_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got psel=%b pen=%b pw=%b rv=%b busy=%b paddr=%h pwdata=%h rdata=%h want all 0",
                     psel, penable, pwrite, rsp_valid, busy, paddr, pwdata, rsp_rdata);
        end
        rst = 1'b0;
        tick;
        n_vec++;
        if ({cmd_ready, busy, psel} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release got ready=%b busy=%b psel=%b want 1 0 0",
                     cmd_ready, busy, psel);
        end
    endtask

    task automatic test_single_write;
        clear_logs();
        cmd_write = 1'b1;
        cmd_addr  = 7'h08;
        cmd_wdata = 32'hA5A5_0001;
        cmd_valid = 1'b1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_ready got %b want 1", cmd_ready);
        end
        model_cmd(1'b1, 7'h08, 32'hA5A5_0001);
        tick;
        cmd_valid = 1'b0;
        n_vec++;
        if (psel !== 1'b0) begin
            n_err++;
            $display("FAIL wr_n1_psel got %b want 0", psel);
        end
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 7'h08, 32'hA5A5_0001}) begin
            n_err++;
            $display("FAIL wr_setup got psel=%b pen=%b pw=%b paddr=%h pwdata=%h want 1 0 1 08 a5a50001",
                     psel, penable, pwrite, paddr, pwdata);
        end
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr} !== {3'b111, 7'h08}) begin
            n_err++;
            $display("FAIL wr_access got psel=%b pen=%b pw=%b paddr=%h want 1 1 1 08",
                     psel, penable, pwrite, paddr);
        end
        tick;
        n_vec++;
        if ({psel, penable, rsp_valid, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL wr_done got psel=%b pen=%b rv=%b busy=%b want 0 0 0 0",
                     psel, penable, rsp_valid, busy);
        end
        n_vec++;
        if (apb_log.size() != 1 || apb_log[0] !== exp_apb[0]) begin
            n_err++;
            $display("FAIL wr_log got %0d xfers first=%h want 1 xfer %h",
                     apb_log.size(), apb_log.size() > 0 ? apb_log[0] : '0, exp_apb[0]);
        end
    endtask

    task automatic test_single_read;
        clear_logs();
        vmem[7'h10] = 32'hDEAD_BEEF;
        mreg[7'h10] = 32'hDEAD_BEEF;
        rsp_ready = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 7'h10;
        cmd_wdata = $urandom;
        cmd_valid = 1'b1;
        model_cmd(1'b0, 7'h10, 32'h0);
        tick;
        cmd_valid = 1'b0;
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b100, 7'h10, 32'h0}) begin
            n_err++;
            $display("FAIL rd_setup got psel=%b pen=%b pw=%b paddr=%h pwdata=%h want 1 0 0 10 0",
                     psel, penable, pwrite, paddr, pwdata);
        end
        tick;
        n_vec++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            n_err++;
            $display("FAIL rd_access got psel=%b pen=%b rv=%b want 1 1 0", psel, penable, rsp_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp[0] || psel !== 1'b0) begin
                n_err++;
                $display("FAIL rd_hold[%0d] got rv=%b rdata=%h psel=%b want 1 %h 0",
                         k, rsp_valid, rsp_rdata, psel, exp_rsp[0]);
            end
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, busy} !== 2'b00 || rsp_log.size() != 1) begin
            n_err++;
            $display("FAIL rd_accept got rv=%b busy=%b rsps=%0d want 0 0 1",
                     rsp_valid, busy, rsp_log.size());
        end
    endtask

    task automatic test_fifo_full;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic ep;
        logic ee;
        clear_logs();
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c < 5) begin
                a = 7'($urandom);
                d = $urandom;
                cmd_addr  = a;
                cmd_wdata = d;
                n_vec++;
                if (cmd_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_ready[%0d] got %b want 1", c, cmd_ready);
                end
                model_cmd(1'b1, a, d);
            end else if (c == 5) begin
                cmd_valid = 1'b0;
                n_vec++;
                if (cmd_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_stall got ready=%b want 0", cmd_ready);
                end
            end
            ep = (c >= 2 && c <= 11);
            ee = ep && (c % 2 == 1);
            n_vec++;
            if ({psel, penable} !== {ep, ee}) begin
                n_err++;
                $display("FAIL full_b2b[%0d] got psel=%b pen=%b want %b %b", c, psel, penable, ep, ee);
            end
            tick;
        end
        drain("full");
        n_vec++;
        if (apb_log.size() != exp_apb.size()) begin
            n_err++;
            $display("FAIL full_count got %0d want %0d", apb_log.size(), exp_apb.size());
        end
        foreach (exp_apb[i]) begin
            if (i < apb_log.size()) begin
                n_vec++;
                if (apb_log[i] !== exp_apb[i]) begin
                    n_err++;
                    $display("FAIL full_xfer[%0d] got %h want %h", i, apb_log[i], exp_apb[i]);
                end
            end
        end
    endtask

    task automatic test_rsp_stall;
        logic [AW-1:0] a [3];
        logic [DW-1:0] d;
        clear_logs();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a[k] = 7'($urandom);
            d = $urandom;
            cmd_write = (k == 2);
            cmd_addr  = a[k];
            cmd_wdata = d;
            n_vec++;
            if (cmd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stall_ready[%0d] got %b want 1", k, cmd_ready);
            end
            model_cmd(k == 2, a[k], d);
            tick;
        end
        cmd_valid = 1'b0;
        tick;
        for (int j = 0; j < 10; j++) begin
            n_vec++;
            if (psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_rsp[0]) begin
                n_err++;
                $display("FAIL stall_hold[%0d] got psel=%b rv=%b rdata=%h want 0 1 %h",
                         j, psel, rsp_valid, rsp_rdata, exp_rsp[0]);
            end
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, psel} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_pop got rv=%b psel=%b want 0 0", rsp_valid, psel);
        end
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr} !== {3'b100, a[1]}) begin
            n_err++;
            $display("FAIL stall_rd2 got psel=%b pen=%b pw=%b paddr=%h want 1 0 0 %h",
                     psel, penable, pwrite, paddr, a[1]);
        end
        tick;
        tick;
        n_vec++;
        if ({psel, penable, pwrite, paddr, rsp_valid} !== {3'b101, a[2], 1'b1}
            || rsp_rdata !== exp_rsp[1]) begin
            n_err++;
            $display("FAIL stall_wr got psel=%b pen=%b pw=%b paddr=%h rv=%b rdata=%h want 1 0 1 %h 1 %h",
                     psel, penable, pwrite, paddr, rsp_valid, rsp_rdata, a[2], exp_rsp[1]);
        end
        drain("stall");
        n_vec++;
        if (apb_log.size() != 3 || rsp_log.size() != 2) begin
            n_err++;
            $display("FAIL stall_count got %0d xfers %0d rsps want 3 2", apb_log.size(), rsp_log.size());
        end
        foreach (exp_apb[i]) begin
            if (i < apb_log.size()) begin
                n_vec++;
                if (apb_log[i] !== exp_apb[i]) begin
                    n_err++;
                    $display("FAIL stall_xfer[%0d] got %h want %h", i, apb_log[i], exp_apb[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        clear_logs();
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_addr  = 7'h40 + 7'(k);
            cmd_wdata = $urandom;
            tick;
        end
        n_vec++;
        if ({psel, penable} !== 2'b11) begin
            n_err++;
            $display("FAIL rstmid_access got psel=%b pen=%b want 1 1", psel, penable);
        end
        cmd_addr = 7'h43;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({psel, penable} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_drop got psel=%b pen=%b want 0 0", psel, penable);
        end
        cmd_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick;
            n_vec++;
            if ({busy, cmd_ready, psel, rsp_valid} !== 4'b0100) begin
                n_err++;
                $display("FAIL rstmid_after[%0d] got busy=%b ready=%b psel=%b rv=%b want 0 1 0 0",
                         j, busy, cmd_ready, psel, rsp_valid);
            end
        end
        n_vec++;
        if (apb_log.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_xfers got %0d want 0", apb_log.size());
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int pushes;
        int cyc;
        clear_logs();
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 7'($urandom);
            d = $urandom;
            cmd_addr  = a;
            cmd_wdata = d;
            model_cmd(1'b1, a, d);
            tick;
        end
        pushes = 0;
        cyc = 0;
        while (pushes < 14 && cyc < 60) begin
            if (penable === 1'b1) begin
                a = 7'($urandom);
                d = $urandom;
                cmd_valid = 1'b1;
                cmd_addr  = a;
                cmd_wdata = d;
                n_vec++;
                if (cmd_ready !== 1'b1 || psel !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap_push[%0d] got ready=%b psel=%b want 1 1", pushes, cmd_ready, psel);
                end
                model_cmd(1'b1, a, d);
                pushes++;
            end else begin
                cmd_valid = 1'b0;
            end
            tick;
            cyc++;
        end
        n_vec++;
        if (pushes != 14) begin
            n_err++;
            $display("FAIL wrap_progress got %0d pushes want 14", pushes);
        end
        drain("wrap");
        n_vec++;
        if (apb_log.size() != exp_apb.size()) begin
            n_err++;
            $display("FAIL wrap_count got %0d want %0d", apb_log.size(), exp_apb.size());
        end
        foreach (exp_apb[i]) begin
            if (i < apb_log.size()) begin
                n_vec++;
                if (apb_log[i] !== exp_apb[i]) begin
                    n_err++;
                    $display("FAIL wrap_xfer[%0d] got %h want %h", i, apb_log[i], exp_apb[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic          hold;
        logic [DW-1:0] held;
        clear_logs();
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 400; c++) begin
            if (hold) begin
                n_vec++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== held) begin
                    n_err++;
                    $display("FAIL rand_rsp_stable[%0d] got rv=%b rdata=%h want 1 %h",
                             c, rsp_valid, rsp_rdata, held);
                end
            end
            cmd_valid = ($urandom % 3) != 0;
            cmd_write = $urandom % 2;
            cmd_addr  = 7'($urandom_range(0, 15));
            cmd_wdata = $urandom;
            rsp_ready = ($urandom % 4) == 0;
            hold = rsp_valid && !rsp_ready;
            held = rsp_rdata;
            if (cmd_valid && cmd_ready) model_cmd(cmd_write, cmd_addr, cmd_wdata);
            tick;
        end
        drain("rand");
        n_vec++;
        if (apb_log.size() != exp_apb.size() || rsp_log.size() != exp_rsp.size()) begin
            n_err++;
            $display("FAIL rand_count got %0d xfers %0d rsps want %0d %0d",
                     apb_log.size(), rsp_log.size(), exp_apb.size(), exp_rsp.size());
        end
        foreach (exp_apb[i]) begin
            if (i < apb_log.size()) begin
                n_vec++;
                if (apb_log[i] !== exp_apb[i]) begin
                    n_err++;
                    $display("FAIL rand_xfer[%0d] got %h want %h", i, apb_log[i], exp_apb[i]);
                end
            end
        end
        foreach (exp_rsp[i]) begin
            if (i < rsp_log.size()) begin
                n_vec++;
                if (rsp_log[i] !== exp_rsp[i]) begin
                    n_err++;
                    $display("FAIL rand_rsp[%0d] got %h want %h", i, rsp_log[i], exp_rsp[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            vmem[i] = 32'hC0DE_0000 | 32'(i);
            mreg[i] = 32'hC0DE_0000 | 32'(i);
        end
        test_reset();
        test_single_write();
        test_single_read();
        test_fifo_full();
        test_rsp_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
